// File: rtl/satswarmv2_pkg.sv
// Shared NoC types for the SAT-swarm fabric: message kinds, the 80-bit
// packet layout and the field widths the receive path depends on.
package satswarmv2_pkg;

    localparam int CORE_ID_W = 4;
    localparam int LBD_W     = 4;

    typedef enum logic [1:0] {
        MSG_DIVERGE = 2'b00,
        MSG_CLAUSE  = 2'b01,
        MSG_STATUS  = 2'b10
    } msg_type_t;

    // Reserved encoding; never stored, always filtered on receive.
    localparam logic [1:0] MSG_INVALID = 2'b11;

    typedef struct packed {
        msg_type_t              msg_type;
        logic [CORE_ID_W-1:0]   dst_id;
        logic [CORE_ID_W-1:0]   src_id;
        logic [1:0]             virtual_channel;
        logic [LBD_W-1:0]       quality_metric;
        logic [63:0]            payload;
    } noc_packet_t;

    localparam int NOC_PKT_W = $bits(noc_packet_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; full/empty come from the count,
// pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_W'(1);
        if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; readers gate it with empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/noc_rx_dispatch.sv
// Receive side of a core's NoC port: filters unwanted packets, buffers the
// rest in order and presents the head on the port chosen by its msg_type.
module noc_rx_dispatch
    import satswarmv2_pkg::*;
#(
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [CORE_ID_W-1:0] CORE_ID    = '0,
    parameter int                   LBD_MAX    = 6,
    localparam int                  OCC_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  noc_packet_t          in_pkt,
    output logic                 div_valid,
    input  logic                 div_ready,
    output logic [31:0]          div_lit,
    output logic                 cls_valid,
    input  logic                 cls_ready,
    output logic [63:0]          cls_lits,
    output logic [LBD_W-1:0]     cls_lbd,
    output logic                 sts_valid,
    input  logic                 sts_ready,
    output logic [63:0]          sts_payload,
    output logic [CORE_ID_W-1:0] out_src_id,
    output logic [15:0]          drop_cnt,
    output logic [OCC_W-1:0]     occupancy
);

    logic                 fifo_full, fifo_empty;
    logic [NOC_PKT_W-1:0] fifo_rdata;
    noc_packet_t          head_pkt;
    logic                 accept, filtered, push, pop;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic                 unused_head_bits;

    sync_fifo #(
        .WIDTH (NOC_PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_pkt),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        filtered = 1'b0;
        if (in_pkt.msg_type == MSG_INVALID) filtered = 1'b1;
        if (in_pkt.msg_type == MSG_CLAUSE &&
            (in_pkt.src_id == CORE_ID || int'(in_pkt.quality_metric) > LBD_MAX))
            filtered = 1'b1;
    end

    assign push = accept && !filtered;

    // Zero the head when empty so uninitialised storage never reaches a port.
    assign head_pkt = fifo_empty ? '0 : noc_packet_t'(fifo_rdata);

    assign div_valid = !fifo_empty && (head_pkt.msg_type == MSG_DIVERGE);
    assign cls_valid = !fifo_empty && (head_pkt.msg_type == MSG_CLAUSE);
    assign sts_valid = !fifo_empty && (head_pkt.msg_type == MSG_STATUS);

    assign pop = (div_valid && div_ready) ||
                 (cls_valid && cls_ready) ||
                 (sts_valid && sts_ready);

    assign div_lit     = head_pkt.payload[31:0];
    assign cls_lits    = head_pkt.payload;
    assign cls_lbd     = head_pkt.quality_metric;
    assign sts_payload = head_pkt.payload;
    assign out_src_id  = head_pkt.src_id;

    // Routing fields travel with the packet but are not consumed here.
    assign unused_head_bits = ^{head_pkt.dst_id, head_pkt.virtual_channel};

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && filtered && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_noc_rx_dispatch.sv
// Directed bench for noc_rx_dispatch: latency, filtering, backpressure,
// head-of-line blocking, drop counter saturation and mid-handshake reset.
module tb_noc_rx_dispatch;
    import satswarmv2_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    noc_packet_t          in_pkt;
    logic                 div_valid, div_ready;
    logic [31:0]          div_lit;
    logic                 cls_valid, cls_ready;
    logic [63:0]          cls_lits;
    logic [LBD_W-1:0]     cls_lbd;
    logic                 sts_valid, sts_ready;
    logic [63:0]          sts_payload;
    logic [CORE_ID_W-1:0] out_src_id;
    logic [15:0]          drop_cnt;
    logic [2:0]           occupancy;

    int checks = 0;
    int errors = 0;

    noc_rx_dispatch #(
        .FIFO_DEPTH (4),
        .CORE_ID    (4'd0),
        .LBD_MAX    (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pkt      (in_pkt),
        .div_valid   (div_valid),
        .div_ready   (div_ready),
        .div_lit     (div_lit),
        .cls_valid   (cls_valid),
        .cls_ready   (cls_ready),
        .cls_lits    (cls_lits),
        .cls_lbd     (cls_lbd),
        .sts_valid   (sts_valid),
        .sts_ready   (sts_ready),
        .sts_payload (sts_payload),
        .out_src_id  (out_src_id),
        .drop_cnt    (drop_cnt),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 2 ns later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic noc_packet_t mk(input logic [1:0] mt, input logic [3:0] src,
                                       input logic [3:0] lbd, input logic [63:0] pl);
        noc_packet_t p;
        p.msg_type        = msg_type_t'(mt);
        p.dst_id          = 4'd0;
        p.src_id          = src;
        p.virtual_channel = 2'd1;
        p.quality_metric  = lbd;
        p.payload         = pl;
        return p;
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_pkt = mk(2'b00, 4'd0, 4'd0, 64'd0);
        div_ready = 1'b0;
        cls_ready = 1'b0;
        sts_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_occ", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_valids", {div_valid, cls_valid, sts_valid}, 0);
        check("rst_drop", drop_cnt, 0);

        // Divergence packet with everything ready: valid at N+1, popped at N+1.
        div_ready = 1'b1; cls_ready = 1'b1; sts_ready = 1'b1;
        in_valid = 1'b1;
        in_pkt = mk(2'b00, 4'd3, 4'd0, 64'h0000_0000_FFFF_FFF9);
        cyc();
        in_valid = 1'b0;
        check("div_valid_n1", div_valid, 1);
        check("div_lit", div_lit, 32'hFFFF_FFF9);
        check("div_occ1", occupancy, 1);
        check("div_others_low", {cls_valid, sts_valid}, 0);
        check("div_src", out_src_id, 3);
        cyc();
        check("div_occ0", occupancy, 0);
        check("div_valid_gone", div_valid, 0);
        div_ready = 1'b0; cls_ready = 1'b0; sts_ready = 1'b0;

        // Clause filtering: loopback, excessive lbd, then an accepted one at the limit.
        in_valid = 1'b1;
        in_pkt = mk(2'b01, 4'd0, 4'd2, 64'h1111);
        cyc();
        check("loop_drop", drop_cnt, 1);
        check("loop_occ", occupancy, 0);
        in_pkt = mk(2'b01, 4'd1, 4'd9, 64'h2222);
        cyc();
        check("lbd_drop", drop_cnt, 2);
        check("lbd_occ", occupancy, 0);
        in_pkt = mk(2'b01, 4'd1, 4'd6, 64'hCAFE_0000_BEEF_0001);
        cyc();
        in_valid = 1'b0;
        check("cls_valid", cls_valid, 1);
        check("cls_lbd", cls_lbd, 6);
        check("cls_lits", cls_lits, 64'hCAFE_0000_BEEF_0001);
        check("cls_src", out_src_id, 1);
        check("cls_drop_same", drop_cnt, 2);
        sts_ready = 1'b1;
        cyc();
        check("cls_no_pop_wrong_ready", occupancy, 1);
        sts_ready = 1'b0;
        cls_ready = 1'b1;
        cyc();
        cls_ready = 1'b0;
        check("cls_popped", occupancy, 0);

        // Backpressure: four status packets fill the FIFO, the fifth waits.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pkt = mk(2'b10, 4'd5, 4'd0, 64'h100 + 64'(i));
            cyc();
        end
        in_pkt = mk(2'b10, 4'd5, 4'd0, 64'h104);
        check("full_in_ready", in_ready, 0);
        check("full_occ", occupancy, 4);
        cyc();
        check("held_occ", occupancy, 4);
        check("held_head", sts_payload, 64'h100);
        sts_ready = 1'b1;
        cyc();
        sts_ready = 1'b0;
        check("pulse_in_ready", in_ready, 1);
        check("pulse_occ", occupancy, 3);
        check("pulse_head", sts_payload, 64'h101);
        cyc();
        in_valid = 1'b0;
        check("fifth_occ", occupancy, 4);
        sts_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("drain_valid", sts_valid, 1);
            check("drain_order", sts_payload, 64'h100 + 64'(i));
            cyc();
        end
        sts_ready = 1'b0;
        check("drain_occ", occupancy, 0);

        // Head-of-line blocking: only the clause port ready, divergence at head.
        in_valid = 1'b1;
        in_pkt = mk(2'b00, 4'd1, 4'd0, 64'hA000_0000_1234_5678);
        cyc();
        in_pkt = mk(2'b01, 4'd2, 4'd3, 64'hB000_0001_0000_0002);
        cyc();
        in_pkt = mk(2'b10, 4'd3, 4'd0, 64'hC000_0000_0000_0003);
        cyc();
        in_valid = 1'b0;
        cls_ready = 1'b1;
        check("hol_occ3", occupancy, 3);
        check("hol_div", div_valid, 1);
        check("hol_cls_low", cls_valid, 0);
        cyc();
        cyc();
        check("hol_stall_occ", occupancy, 3);
        check("hol_stall_lit", div_lit, 32'h1234_5678);
        check("hol_stall_src", out_src_id, 1);
        div_ready = 1'b1;
        sts_ready = 1'b1;
        cyc();
        check("hol_cls_valid", cls_valid, 1);
        check("hol_cls_lits", cls_lits, 64'hB000_0001_0000_0002);
        check("hol_cls_lbd", cls_lbd, 3);
        check("hol_cls_src", out_src_id, 2);
        check("hol_nonsel_div_lit", div_lit, 32'h0000_0002);
        cyc();
        check("hol_sts_valid", sts_valid, 1);
        check("hol_sts_payload", sts_payload, 64'hC000_0000_0000_0003);
        cyc();
        check("hol_empty", occupancy, 0);
        check("hol_valids_low", {div_valid, cls_valid, sts_valid}, 0);
        div_ready = 1'b0; cls_ready = 1'b0; sts_ready = 1'b0;

        // Drop counter saturation: two drops so far, run it up to FFFE then past.
        in_valid = 1'b1;
        in_pkt = mk(2'b11, 4'd7, 4'd0, 64'hDEAD);
        repeat (16'hFFFE - 2) cyc();
        check("sat_fffe", drop_cnt, 16'hFFFE);
        check("sat_occ", occupancy, 0);
        cyc();
        check("sat_ffff", drop_cnt, 16'hFFFF);
        cyc();
        cyc();
        in_valid = 1'b0;
        check("sat_hold", drop_cnt, 16'hFFFF);

        // Reset in the middle of a status handshake with three entries queued.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pkt = mk(2'b10, 4'd4, 4'd0, 64'h200 + 64'(i));
            cyc();
        end
        in_valid = 1'b0;
        check("pre_rst_occ", occupancy, 3);
        sts_ready = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sts_ready = 1'b0;
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_valids", {div_valid, cls_valid, sts_valid}, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        cyc();
        check("post_rst_occ", occupancy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
